// File: rtl/key_uart_pkg.sv
// rtl/key_uart_pkg.sv - shared constants and state encoding for the key-to-UART byte path
package key_uart_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_GAP_CYC = 16;
    localparam int DEF_TIMEOUT = 2000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_e;

    // Width of a counter that must hold values up to max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with occupancy count and combinational head
module byte_fifo
    import key_uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the same cycle frees the head slot.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the cleared pointers make old contents unreachable.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/key_tx_queue.sv
// rtl/key_tx_queue.sv - byte queue and send scheduler between key control and the UART transmitter
module key_tx_queue
    import key_uart_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              tx_done_i,
    input  logic              uart_state_i,
    output logic              send_en_o,
    output logic [BYTE_W-1:0] data_byte_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o,
    output logic              ovf_o,
    output logic              tmo_o
);

    localparam int GW = cnt_width(GAP_CYC);
    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    tx_state_e         state_q, state_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              send_en_q, send_en_d;
    logic [BYTE_W-1:0] data_byte_q, data_byte_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_head;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (wr_en_i),
        .wr_data_i (wr_data_i),
        .pop_i     (fifo_pop),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count_o)
    );

    assign full_o      = fifo_full;
    assign empty_o     = fifo_empty;
    assign send_en_o   = send_en_q;
    assign data_byte_o = data_byte_q;
    assign ovf_o       = ovf_q;
    assign tmo_o       = tmo_q;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !uart_state_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop  = 1'b1;
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done_i) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // The aborted byte is already popped and is not retried.
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobe and byte are registered on entry to LOAD so both are valid during that cycle.
    always_comb begin
        send_en_d   = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        data_byte_d = send_en_d ? fifo_head : data_byte_q;
        ovf_d       = ovf_q | (wr_en_i & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            send_en_q   <= 1'b0;
            data_byte_q <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            send_en_q   <= send_en_d;
            data_byte_q <= data_byte_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: doc/key_tx_queue.md
Name: key_tx_queue

Overview:
- Byte queue and send scheduler between the key-control stage (producer of data byte + one-cycle send strobe) and the UART byte transmitter (consumer of data_byte/send_en, returns Tx_Done pulse and uart_state busy).
- Buffers key-generated bytes so that presses arriving during an ongoing UART frame are not lost.
- Issues exactly one send strobe per byte, waits for frame completion, then enforces an inter-byte gap.
- Includes a done-timeout so a stuck transmitter cannot deadlock the queue.

Parameters:
- DEPTH, 8, queue depth in bytes; power of two, at least 2.
- AW, 3, pointer width, equal to log2(DEPTH).
- GAP_CYC, 16, idle Clk cycles inserted after each Tx_Done before the next load; 0 means no gap.
- TIMEOUT, 2000000, max Clk cycles in WAIT_DONE before abort.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe from key control.
- wr_data  in  8  byte to enqueue.
- tx_done  in  1  one-cycle frame-complete pulse from UART tx.
- uart_state  in  1  UART tx busy level.
- send_en  out  1  one-cycle start strobe to UART tx.
- data_byte  out  8  byte to transmit; stable from the send_en cycle until the next load.
- full  out  1  count equals DEPTH.
- empty  out  1  count equals 0.
- count  out  AW+1  current occupancy.
- ovf  out  1  sticky; set on a dropped write.
- tmo  out  1  sticky; set on a timeout abort.

Behaviour:
- Reset, asynchronous:
  - pointers and count cleared; state IDLE; counters cleared.
  - send_en=0, data_byte=0, full=0, empty=1, ovf=0, tmo=0.
  - Queue contents are discarded.
  - A reset mid-frame abandons the frame; no Tx_Done is expected afterwards.
- Write rules:
  - wr_en with count<DEPTH: store at the write pointer, advance the pointer (wraps modulo DEPTH), count+1 on the next edge.
  - wr_en while full and no pop in the same cycle: byte dropped, ovf set.
  - wr_en while full with a pop in the same cycle: write accepted, count unchanged.
  - Simultaneous write and pop when not full: count unchanged, both pointers advance.
- State machine, registered:
  - IDLE: if !empty and !uart_state, go to LOAD.
  - LOAD, one cycle:
    - pop the head into data_byte and advance the read pointer;
    - send_en=1 in this cycle only;
    - go to WAIT_DONE and clear the timeout counter.
  - WAIT_DONE:
    - tx_done=1: go to GAP with the gap counter cleared; if GAP_CYC=0, go directly to IDLE.
    - timeout counter reaches TIMEOUT-1 without tx_done: set tmo, go to IDLE.
    - The byte is not re-queued after a timeout.
  - GAP: count GAP_CYC cycles, then go to IDLE.
  - A tx_done pulse in any state other than WAIT_DONE is ignored.
- Latency:
  - A write to an empty queue in cycle N (transmitter idle): count=1 at N+1, IDLE sees it and moves to LOAD at N+2, send_en high during cycle N+2.
  - Minimum byte-to-byte spacing: Tx_Done + GAP_CYC + 2 cycles.
- Outputs:
  - send_en is registered, never high for 2 consecutive cycles, and only asserted in LOAD.
  - full and empty are derived from the registered count.
- The counters are wide enough for TIMEOUT and GAP_CYC; the timeout counter saturates and does not wrap.

Decomposition:
- Shared package key_uart_pkg:
  - state encoding constants (IDLE, LOAD, WAIT_DONE, GAP);
  - default GAP_CYC and TIMEOUT;
  - byte width constant 8.
- One sub-module, byte_fifo (DEPTH/AW parameterised):
  - storage, pointers, count, full/empty;
  - push/pop ports, combinational head data.
- The scheduler FSM, gap and timeout counters live in key_tx_queue.

Test Plan:
- Reset check: Rst high mid-WAIT_DONE with count=3 -> immediately send_en=0, count=0, empty=1, data_byte=0x00, state IDLE; no send after release until a new write.
- Single byte: write 0x31 in cycle 10, uart_state=0 -> send_en in cycle 12 with data_byte=0x31; after tx_done at cycle 100, the next load is possible no earlier than cycle 118 (GAP_CYC=16).
- Burst while busy: write 0x01..0x05 back-to-back while the first frame is in progress -> five send_en pulses in order 0x01..0x05, each after a tx_done, and count returns to 0.
- Overflow: DEPTH=8, hold uart_state=1, write 0x10..0x18 (9 bytes) -> full=1 after 8 writes, ovf=1, byte 0x18 lost; after release, 0x10..0x17 are sent in order.
- Full with pop: queue full, write 0xAA in the LOAD cycle -> accepted, ovf stays 0, count stays 8, 0xAA sent last.
- Timeout: TIMEOUT=50, send one byte, never assert tx_done -> tmo=1 exactly 50 cycles after the WAIT_DONE entry, FSM back in IDLE; the next queued byte is sent normally; a late tx_done is ignored.
